// File: rtl/pwm_fade_ctrl_if.sv
// Command handshake between the control logic (buttons / UART decoder) and
// pwm_fade_ctrl. The master offers a target duty; the slave takes it when
// cmd_valid and cmd_ready are both high on a clock edge.
interface pwm_fade_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_target;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, output cmd_ready);
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for the PWM block. It accepts a target duty over the
// cmd handshake and ramps on_time toward it by one sample every STEP_PERIODS
// PWM periods. on_time only changes on the edge that ends a pcnt==SAMPLES
// cycle, so every PWM period runs with a single, glitch-free duty.
//
// Optional feature macro: PWM_FADE_CLAMP_EN
//   defined   - targets above SAMPLES are latched as SAMPLES (ramp stops at 100%)
//   undefined - targets are latched unmodified
module pwm_fade_ctrl #(
  parameter int unsigned SAMPLES      = 200,  // PWM period is SAMPLES+1 clocks
  parameter int unsigned STEP_PERIODS = 4     // PWM periods per ramp step, 1..255
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_fade_ctrl_if.slave        cmd,
  input  logic                  stop,
  output logic [7:0]            on_time,
  output logic                  busy,
  output logic                  done,
  output logic                  period_start
);

  localparam logic [7:0] LAST_SAMPLE = 8'(SAMPLES);
  localparam logic [7:0] LAST_STEP   = 8'(STEP_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] pcnt;
  logic [7:0] scnt;
  logic [7:0] target;
  logic [7:0] next_target;
  logic [7:0] next_on_time;
  logic [7:0] cmd_target_eff;
  logic [7:0] on_time_inc;
  logic [7:0] on_time_dec;
  logic       next_done;
  logic       period_tick;
  logic       step_tick;
  logic       accept;

  assign period_tick  = (pcnt == LAST_SAMPLE);
  assign step_tick    = period_tick && (scnt == LAST_STEP);
  assign period_start = period_tick;

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign on_time_inc = on_time + 8'd1;
  assign on_time_dec = on_time - 8'd1;

`ifdef PWM_FADE_CLAMP_EN
  // Never ask the PWM for more than a full period of on-time.
  assign cmd_target_eff = (cmd.cmd_target > LAST_SAMPLE) ? LAST_SAMPLE : cmd.cmd_target;
`else
  assign cmd_target_eff = cmd.cmd_target;
`endif

  // Free-running PWM period counter: 0..SAMPLES, then wrap.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (rst) begin
      pcnt <= '0;
    end else if (period_tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

  // Step counter: counts period ticks, restarts on each accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
    end else if (accept) begin
      scnt <= '0;
    end else if (step_tick) begin
      scnt <= '0;
    end else if (period_tick) begin
      scnt <= scnt + 8'd1;
    end
  end

  // FSM registers: state, latched target, duty output and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      on_time <= '0;
      // NOTE: target is only consulted while ramping, but it is still reset so
      // a reset mid-ramp provably discards whatever command was pending.
      target  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      on_time <= next_on_time;
      target  <= next_target;
      done    <= next_done;
    end
  end

  // Next-state logic: accept in IDLE, one-sample steps in UP/DOWN, stop wins.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    next_state   = state;
    next_on_time = on_time;
    next_target  = target;
    next_done    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          next_target = cmd_target_eff;
          if (cmd_target_eff > on_time) begin
            next_state = UP;
          end else if (cmd_target_eff < on_time) begin
            next_state = DOWN;
          end else begin
            next_done = 1'b1;
          end
        end
      end

      UP: begin
        if (stop) begin
          next_state = IDLE;
        end else if (step_tick) begin
          next_on_time = on_time_inc;
          if (on_time_inc == target) begin
            next_state = IDLE;
            next_done  = 1'b1;
          end
        end
      end

      DOWN: begin
        if (stop) begin
          next_state = IDLE;
        end else if (step_tick) begin
          next_on_time = on_time_dec;
          if (on_time_dec == target) begin
            next_state = IDLE;
            next_done  = 1'b1;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed testbench for pwm_fade_ctrl. The main instance runs SAMPLES=200,
// STEP_PERIODS=2 (one step every 402 clocks); a second instance with
// STEP_PERIODS=1 covers the long ramp to an out-of-range target.
module tb_pwm_fade_ctrl;

  localparam int SAMPLES = 200;
  localparam int STEP    = 2;
  localparam int PERIOD  = SAMPLES + 1;
  localparam int STEP_CYC = STEP * PERIOD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  pwm_fade_ctrl_if cmd_if ();
  logic       stop;
  logic [7:0] on_time;
  logic       busy, done, period_start;

  pwm_fade_ctrl #(.SAMPLES(SAMPLES), .STEP_PERIODS(STEP)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .stop(stop), .on_time(on_time),
    .busy(busy), .done(done), .period_start(period_start)
  );

  // clamp instance
  pwm_fade_ctrl_if cl_if ();
  logic       cl_stop;
  logic [7:0] cl_on_time;
  logic       cl_busy, cl_done, cl_period_start;

  pwm_fade_ctrl #(.SAMPLES(SAMPLES), .STEP_PERIODS(1)) dut_clamp (
    .clk(clk), .rst(rst), .cmd(cl_if), .stop(cl_stop), .on_time(cl_on_time),
    .busy(cl_busy), .done(cl_done), .period_start(cl_period_start)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // observations gathered by watch()
  int         chg_cyc[$];
  logic [7:0] chg_val[$];
  int         done_cyc[$];
  logic [7:0] done_val[$];
  int         bad_edge;
  int         done_not_ready;
  bit         timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command until it is accepted (bounded); returns with valid low.
  task automatic send_cmd(input logic [7:0] tgt, output bit ok);
    int n = 0;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = tgt;
    while (cmd_if.cmd_ready !== 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    ok = (cmd_if.cmd_ready === 1'b1);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Record on_time changes and done pulses (cycles counted from the accept
  // edge) until cmd_ready returns, then for `extra` more cycles.
  task automatic watch(input int limit, input int extra);
    int         cyc = 0;
    int         stop_at = -1;
    logic       prev_ps;
    logic [7:0] prev_ot;
    chg_cyc.delete(); chg_val.delete(); done_cyc.delete(); done_val.delete();
    bad_edge = 0; done_not_ready = 0;
    prev_ps = period_start;
    prev_ot = on_time;
    while (cyc < limit && (stop_at < 0 || cyc < stop_at)) begin
      tick();
      cyc++;
      if (on_time !== prev_ot) begin
        chg_cyc.push_back(cyc);
        chg_val.push_back(on_time);
        if (prev_ps !== 1'b1) bad_edge++;
      end
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        done_val.push_back(on_time);
        if (cmd_if.cmd_ready !== 1'b1) done_not_ready++;
      end
      prev_ps = period_start;
      prev_ot = on_time;
      if (stop_at < 0 && cmd_if.cmd_ready === 1'b1) stop_at = cyc + extra;
    end
    timed_out = (stop_at < 0);
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b1; stop = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_target = '0;
    cl_stop = 1'b0; cl_if.cmd_valid = 1'b0; cl_if.cmd_target = '0;
    repeat (3) tick();
    tests_run++; if (on_time !== 8'd0) begin tests_failed++; $display("FAIL reset_on_time: got %0d expected 0", on_time); end
    tests_run++; if (cmd_if.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_if.cmd_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (period_start !== 1'b0) begin tests_failed++; $display("FAIL reset_period_start: got %b expected 0", period_start); end
    rst = 1'b0;
    while (period_start !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    tests_run++; if (n != 200) begin tests_failed++; $display("FAIL reset_first_period_start: got cycle %0d expected 200", n); end
    tick();
    tests_run++; if (period_start !== 1'b0) begin tests_failed++; $display("FAIL period_start_width: got %b expected 0", period_start); end
  endtask

  task automatic test_ramp_up();
    bit         ok;
    logic [7:0] exp_v;
    send_cmd(8'd3, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL up_accept: got not ready expected ready"); end
    tests_run++; if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL up_busy_after_accept: got busy=%b ready=%b expected busy=1 ready=0", busy, cmd_if.cmd_ready); end
    watch(4 * STEP_CYC, 10);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL up_timeout: got no return to idle expected idle within %0d cycles", 4 * STEP_CYC); end
    tests_run++; if (chg_val.size() != 3) begin tests_failed++; $display("FAIL up_step_count: got %0d expected 3", chg_val.size()); end
    if (chg_val.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        exp_v = 8'(i + 1);
        tests_run++; if (chg_val[i] !== exp_v) begin tests_failed++; $display("FAIL up_step_value[%0d]: got %0d expected %0d", i, chg_val[i], exp_v); end
      end
      tests_run++; if (chg_cyc[0] < STEP_CYC - PERIOD + 1 || chg_cyc[0] > STEP_CYC) begin tests_failed++; $display("FAIL up_first_latency: got %0d expected %0d..%0d", chg_cyc[0], STEP_CYC - PERIOD + 1, STEP_CYC); end
      tests_run++; if (chg_cyc[1] - chg_cyc[0] != 402) begin tests_failed++; $display("FAIL up_gap1: got %0d expected 402", chg_cyc[1] - chg_cyc[0]); end
      tests_run++; if (chg_cyc[2] - chg_cyc[1] != 402) begin tests_failed++; $display("FAIL up_gap2: got %0d expected 402", chg_cyc[2] - chg_cyc[1]); end
      tests_run++; if (done_cyc.size() == 1 && done_cyc[0] != chg_cyc[2]) begin tests_failed++; $display("FAIL up_done_cycle: got %0d expected %0d", done_cyc[0], chg_cyc[2]); end
    end
    tests_run++; if (bad_edge != 0) begin tests_failed++; $display("FAIL up_change_off_tick: got %0d expected 0", bad_edge); end
    tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("FAIL up_done_count: got %0d expected 1", done_cyc.size()); end
    tests_run++; if (done_val.size() == 1 && done_val[0] !== 8'd3) begin tests_failed++; $display("FAIL up_done_value: got %0d expected 3", done_val[0]); end
    tests_run++; if (done_not_ready != 0) begin tests_failed++; $display("FAIL up_done_ready: got %0d expected 0", done_not_ready); end
  endtask

  task automatic test_ramp_down_noop();
    bit         ok;
    logic [7:0] exp_v;
    send_cmd(8'd0, ok);
    tests_run++; if (!ok || busy !== 1'b1) begin tests_failed++; $display("FAIL down_accept: got ok=%b busy=%b expected 1 1", ok, busy); end
    watch(4 * STEP_CYC, 10);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL down_timeout: got no return to idle expected idle"); end
    tests_run++; if (chg_val.size() != 3) begin tests_failed++; $display("FAIL down_step_count: got %0d expected 3", chg_val.size()); end
    if (chg_val.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        exp_v = 8'(2 - i);
        tests_run++; if (chg_val[i] !== exp_v) begin tests_failed++; $display("FAIL down_step_value[%0d]: got %0d expected %0d", i, chg_val[i], exp_v); end
      end
      tests_run++; if (chg_cyc[2] - chg_cyc[1] != 402) begin tests_failed++; $display("FAIL down_gap: got %0d expected 402", chg_cyc[2] - chg_cyc[1]); end
    end
    tests_run++; if (bad_edge != 0) begin tests_failed++; $display("FAIL down_change_off_tick: got %0d expected 0", bad_edge); end
    tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("FAIL down_done_count: got %0d expected 1", done_cyc.size()); end
    tests_run++; if (done_val.size() == 1 && done_val[0] !== 8'd0) begin tests_failed++; $display("FAIL down_done_value: got %0d expected 0", done_val[0]); end
    // no-op: same target again
    send_cmd(8'd0, ok);
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL noop_done: got %b expected 1", done); end
    tests_run++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL noop_idle: got busy=%b ready=%b expected busy=0 ready=1", busy, cmd_if.cmd_ready); end
    tick();
    tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL noop_after: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_stop();
    bit ok;
    int n = 0;
    int pulses = 0;
    int changes = 0;
    int dones = 0;
    send_cmd(8'd10, ok);
    while (on_time !== 8'd2 && n < 3 * STEP_CYC) begin
      tick();
      n++;
    end
    tests_run++; if (on_time !== 8'd2) begin tests_failed++; $display("FAIL stop_reach2: got %0d expected 2", on_time); end
    n = 0;
    while (pulses < STEP && n < 2 * STEP_CYC) begin
      tick();
      n++;
      if (period_start === 1'b1) pulses++;
    end
    // this cycle is the step_tick that would move on_time to 3
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests_run++; if (on_time !== 8'd2) begin tests_failed++; $display("FAIL stop_hold: got %0d expected 2", on_time); end
    tests_run++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL stop_idle: got busy=%b ready=%b expected busy=0 ready=1", busy, cmd_if.cmd_ready); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL stop_no_done: got %b expected 0", done); end
    repeat (2 * STEP_CYC) begin
      tick();
      if (on_time !== 8'd2) changes++;
      if (done === 1'b1) dones++;
    end
    tests_run++; if (changes != 0 || dones != 0) begin tests_failed++; $display("FAIL stop_frozen: got changes=%0d dones=%0d expected 0 0", changes, dones); end
  endtask

  task automatic test_back_to_back();
    bit         ok;
    int         n = 0;
    int         bad_dir = 0;
    logic [7:0] prev;
    logic [7:0] exp_v;
    send_cmd(8'd8, ok);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 8'd5;
    prev = on_time;
    while (cmd_if.cmd_ready !== 1'b1 && n < 8 * STEP_CYC) begin
      tick();
      n++;
      if (on_time !== prev && on_time !== prev + 8'd1) bad_dir++;
      prev = on_time;
    end
    tests_run++; if (bad_dir != 0) begin tests_failed++; $display("FAIL b2b_not_queued: got %0d bad steps expected 0", bad_dir); end
    tests_run++; if (on_time !== 8'd8) begin tests_failed++; $display("FAIL b2b_reach8: got %0d expected 8", on_time); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_with_ready: got %b expected 1", done); end
    tick();
    cmd_if.cmd_valid = 1'b0;
    tests_run++; if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept_on_done: got busy=%b ready=%b expected busy=1 ready=0", busy, cmd_if.cmd_ready); end
    watch(4 * STEP_CYC, 10);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL b2b_timeout: got no return to idle expected idle"); end
    tests_run++; if (chg_val.size() != 3) begin tests_failed++; $display("FAIL b2b_step_count: got %0d expected 3", chg_val.size()); end
    if (chg_val.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        exp_v = 8'(7 - i);
        tests_run++; if (chg_val[i] !== exp_v) begin tests_failed++; $display("FAIL b2b_step_value[%0d]: got %0d expected %0d", i, chg_val[i], exp_v); end
      end
    end
    tests_run++; if (done_cyc.size() != 1 || on_time !== 8'd5) begin tests_failed++; $display("FAIL b2b_final: got dones=%0d on_time=%0d expected 1 5", done_cyc.size(), on_time); end
  endtask

  task automatic test_reset_mid_ramp();
    bit ok;
    int n = 0;
    int moved = 0;
    send_cmd(8'd9, ok);
    while (on_time !== 8'd6 && n < 2 * STEP_CYC) begin
      tick();
      n++;
    end
    tests_run++; if (on_time !== 8'd6) begin tests_failed++; $display("FAIL rstmid_reach6: got %0d expected 6", on_time); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (on_time !== 8'd0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_state: got on_time=%0d busy=%b ready=%b done=%b expected 0 0 1 0", on_time, busy, cmd_if.cmd_ready, done); end
    repeat (2 * STEP_CYC + 50) begin
      tick();
      if (on_time !== 8'd0 || busy !== 1'b0) moved++;
    end
    tests_run++; if (moved != 0) begin tests_failed++; $display("FAIL rstmid_discard: got %0d active cycles expected 0", moved); end
  endtask

  task automatic test_clamp();
    int         n = 0;
    int         steps = 0;
    int         bad = 0;
    int         dones = 0;
    bit         ready_seen = 0;
    logic [7:0] prev;
    logic [7:0] exp_final;
`ifdef PWM_FADE_CLAMP_EN
    exp_final = 8'd200;
`else
    exp_final = 8'd250;
`endif
    cl_if.cmd_valid  = 1'b1;
    cl_if.cmd_target = 8'd250;
    while (cl_if.cmd_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    tick();
    cl_if.cmd_valid = 1'b0;
    prev = cl_on_time;
    n = 0;
    while (!ready_seen && n < 260 * PERIOD) begin
      tick();
      n++;
      if (cl_done === 1'b1) dones++;
      if (cl_on_time !== prev) begin
        steps++;
        if (cl_on_time !== prev + 8'd1) bad++;
      end
      prev = cl_on_time;
      if (cl_if.cmd_ready === 1'b1) ready_seen = 1'b1;
    end
    tests_run++; if (!ready_seen) begin tests_failed++; $display("FAIL clamp_timeout: got no return to idle expected idle"); end
    tests_run++; if (cl_on_time !== exp_final) begin tests_failed++; $display("FAIL clamp_final: got %0d expected %0d", cl_on_time, exp_final); end
    tests_run++; if (steps != int'(exp_final) || bad != 0) begin tests_failed++; $display("FAIL clamp_steps: got steps=%0d bad=%0d expected %0d 0", steps, bad, exp_final); end
    tests_run++; if (dones != 1 || cl_done !== 1'b1) begin tests_failed++; $display("FAIL clamp_done: got count=%0d now=%b expected 1 1", dones, cl_done); end
    repeat (2 * PERIOD) begin
      tick();
      if (cl_on_time !== exp_final) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL clamp_hold: got %0d changes expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_noop();
    test_stop();
    test_back_to_back();
    test_reset_mid_ramp();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
